// File: rtl/mult_16b_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package mult_16b_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_STEPS = 16;
  localparam int PROD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_e;

endpackage

// File: rtl/adder_16b.sv
// 16-bit Kogge-Stone adder: four prefix levels of generate/propagate merging.
module adder_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_i,
  output logic [15:0] s,
  output logic        c_o
);

  logic [15:0] prop_bit;
  logic [15:0] g_lvl;
  logic [15:0] p_lvl;
  logic [15:0] g_nxt;
  logic [15:0] p_nxt;

  always_comb begin
    prop_bit = a ^ b;
    g_lvl    = a & b;
    p_lvl    = prop_bit;
    // Fold the carry-in into bit 0 so the prefix tree needs no extra column.
    g_lvl[0] = g_lvl[0] | (prop_bit[0] & c_i);
    g_nxt    = g_lvl;
    p_nxt    = p_lvl;
    for (int lvl = 0; lvl < 4; lvl++) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << lvl)) begin
          g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i - (1 << lvl)]);
          p_nxt[i] = p_lvl[i] & p_lvl[i - (1 << lvl)];
        end
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    s   = prop_bit ^ {g_lvl[14:0], c_i};
    c_o = g_lvl[15];
  end

endmodule

// File: rtl/mult_16b_seq.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier around adder_16b.
// Optional early termination on zero operands / exhausted multiplier: MULT_16B_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | o_ready, waiting for operands
// RUN   | one partial-product add and right shift per clock
// DONE  | o_valid, product held until i_ready
module mult_16b_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_p,
  output logic        o_busy
);

  import mult_16b_pkg::*;

  generate
    if (WIDTH != MULT_WIDTH || (1 << CNT_W) <= WIDTH) begin : g_bad_param
      $error("mult_16b_seq: WIDTH must be 16 and CNT_W must hold WIDTH");
    end
  endgenerate

  logic [1:0]            state_q;
  logic [WIDTH-1:0]      mcand_q;
  logic [WIDTH-1:0]      acc_hi_q;
  logic [WIDTH-1:0]      acc_lo_q;
  logic [CNT_W-1:0]      count_q;
  logic [PROD_WIDTH-1:0] p_q;

  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_s;
  logic                  add_co;
  logic [PROD_WIDTH-1:0] shift_next;
  logic [PROD_WIDTH-1:0] prod_final;
  logic [CNT_W-1:0]      count_next;
  logic                  finish;
  logic                  opnd_zero;

  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  adder_16b u_step_adder (
    .a   (acc_hi_q),
    .b   (add_b),
    .c_i (1'b0),
    .s   (add_s),
    .c_o (add_co)
  );

  always_comb begin
    shift_next = {add_co, add_s, acc_lo_q[WIDTH-1:1]};
    count_next = count_q + 1'b1;
    finish     = (count_q == CNT_W'(MULT_STEPS - 1));
    prod_final = shift_next;
    opnd_zero  = 1'b0;
`ifdef MULT_16B_EARLY_TERM_EN
    opnd_zero  = (i_a == '0) || (i_b == '0);
    // Unconsumed multiplier bits sit in the low (16-count) bits of acc_lo.
    if ((shift_next[WIDTH-1:0] << count_next) == '0) begin
      finish     = 1'b1;
      prod_final = shift_next >> (CNT_W'(MULT_STEPS) - count_next);
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            mcand_q  <= i_a;
            acc_lo_q <= i_b;
            acc_hi_q <= '0;
            count_q  <= '0;
            if (opnd_zero) begin
              p_q     <= '0;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (finish) begin
            {acc_hi_q, acc_lo_q} <= prod_final;
            p_q                  <= prod_final;
            count_q              <= CNT_W'(MULT_STEPS);
            state_q              <= DONE;
          end else begin
            {acc_hi_q, acc_lo_q} <= shift_next;
            count_q              <= count_next;
          end
        end
        DONE: begin
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == RUN);
  assign o_valid = (state_q == DONE);
  assign o_p     = p_q;

endmodule

// File: tb/tb_mult_16b_seq.sv
// Directed self-checking bench for mult_16b_seq (default and early-termination builds).
module tb_mult_16b_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_p;
  logic        o_busy;

  int tests;
  int fails;
  int lat;

  mult_16b_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_p     (o_p),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Waits for o_ready, presents operands for exactly one accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    while (!o_ready && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) check("ready_timeout", 32'(o_ready), 32'h1);
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until o_valid is observed.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!o_valid && edges < 40) begin
      tick();
      edges++;
    end
    if (edges >= 40) check("valid_timeout", 32'(o_valid), 32'h1);
  endtask

  task automatic check_lat(input string tag, input int observed);
`ifdef MULT_16B_EARLY_TERM_EN
    check(tag, 32'(observed <= 16), 32'h1);
`else
    check(tag, 32'(observed), 32'd16);
`endif
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a     = '0;
    i_b     = '0;
    #1;
    check("rst_ready", 32'(o_ready), 32'h1);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_busy",  32'(o_busy),  32'h0);
    check("rst_p",     o_p,          32'h0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // Basic 3*5
    start_op(16'd3, 16'd5);
    check("run_busy",  32'(o_busy),  32'h1);
    check("run_ready", 32'(o_ready), 32'h0);
    wait_done(lat);
    check_lat("lat_3x5", lat);
    check("p_3x5", o_p, 32'h0000000F);
    tick();
    check("post_hs_ready", 32'(o_ready), 32'h1);
    check("post_hs_valid", 32'(o_valid), 32'h0);
    check("post_hs_p",     o_p,          32'h0000000F);

    // Carry stress
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(lat);
    check_lat("lat_ffff", lat);
    check("p_ffff", o_p, 32'hFFFE0001);
    start_op(16'h8000, 16'h8000);
    wait_done(lat);
    check_lat("lat_8000", lat);
    check("p_8000", o_p, 32'h40000000);

    // Backpressure
    tick();
    i_ready = 1'b0;
    start_op(16'h1234, 16'h0010);
    wait_done(lat);
    check_lat("lat_bp", lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_p",     o_p,          32'h00012340);
      check("bp_valid", 32'(o_valid), 32'h1);
      check("bp_ready", 32'(o_ready), 32'h0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    check("bp_rel_ready", 32'(o_ready), 32'h1);
    check("bp_rel_valid", 32'(o_valid), 32'h0);
    check("bp_rel_p",     o_p,          32'h00012340);

    // Operands offered while busy must be ignored
    start_op(16'd2, 16'd3);
    check("ign_busy", 32'(o_busy), 32'h1);
    i_a     = 16'hFFFF;
    i_b     = 16'hFFFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_done(lat);
    check("p_ignored", o_p, 32'h00000006);
    tick();

    // Reset mid-RUN at step 8
    start_op(16'hABCD, 16'h1357);
    repeat (8) tick();
    check("pre_rst_busy", 32'(o_busy), 32'h1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'h1);
    check("mid_rst_valid", 32'(o_valid), 32'h0);
    check("mid_rst_busy",  32'(o_busy),  32'h0);
    check("mid_rst_p",     o_p,          32'h0);
    tick();
    i_rst = 1'b0;
    tick();
    start_op(16'd7, 16'd9);
    wait_done(lat);
    check_lat("lat_7x9", lat);
    check("p_7x9", o_p, 32'd63);
    tick();

    // Zero operand and short multiplier
    start_op(16'h0000, 16'h55AA);
    wait_done(lat);
`ifdef MULT_16B_EARLY_TERM_EN
    check("lat_zero", 32'(lat), 32'd0);
`else
    check("lat_zero", 32'(lat), 32'd16);
`endif
    check("p_zero", o_p, 32'h0);
    tick();
    start_op(16'h00FF, 16'h0003);
    wait_done(lat);
`ifdef MULT_16B_EARLY_TERM_EN
    check("lat_short", 32'(lat < 16), 32'h1);
`else
    check("lat_short", 32'(lat), 32'd16);
`endif
    check("p_short", o_p, 32'h000002FD);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
